keypad_entry_buffer: RTL

Downstream consumer of the 12-key keypad priority encoder. Takes the 4-bit encoded key code, where 13 means no key.
- Debounces the code and emits exactly one event per physical press.
- Assembles digit presses into a BCD amount entry with backspace and enter.
- Presents the completed entry to the processor through a valid/ready handshake.

---
 rtl/keypad_entry_buffer.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_entry_buffer.sv
// keypad_entry_buffer: debounces encoded keypad codes into single press events and builds a
// BCD entry handed to the processor by valid/ready. Optional feature macro: ENTRY_TIMEOUT_EN.
module keypad_entry_buffer #(
    parameter int DEBOUNCE_CYCLES = 4,
`ifdef ENTRY_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES  = 50000000,
`endif
    parameter int MAX_DIGITS      = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [3:0]                       key_code,
    output logic                             key_event,
    output logic [3:0]                       last_key,
    output logic [4*MAX_DIGITS-1:0]          entry_bcd,
    output logic [$clog2(MAX_DIGITS+1)-1:0]  digit_count,
    output logic                             overflow,
    output logic                             entry_valid,
`ifdef ENTRY_TIMEOUT_EN
    output logic                             timeout,
`endif
    input  logic                             entry_ready
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int EW = 4 * MAX_DIGITS;
    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]    KEY_NONE  = 4'd13;
    localparam logic [3:0]    KEY_BKSP  = 4'd10;
    localparam logic [3:0]    KEY_ENTER = 4'd11;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        ARMING    = 2'd1,
        PRESSED   = 2'd2,
        RELEASING = 2'd3
    } press_state_t;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } entry_state_t;

    function automatic logic is_key(input logic [3:0] code);
        return (code <= 4'd11);
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

    press_state_t        press_state_r, press_state_s;
    logic [3:0]          cand_r, cand_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic                key_valid_s;
    logic                key_event_r, key_event_s;
    logic [3:0]          last_key_r, last_key_s;

    entry_state_t        entry_state_r, entry_state_s;
    logic [EW-1:0]       entry_bcd_r, entry_bcd_s;
    logic [DW-1:0]       digit_count_r, digit_count_s;
    logic                overflow_r, overflow_s;
    logic                entry_valid_r, entry_valid_s;
    logic                tmo_fire_s;

    assign key_valid_s = is_key(key_code);

    // Press FSM state, debounce counter and registered event outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            press_state_r <= RELEASED;
            cand_r        <= 4'd0;
            cnt_r         <= {CW{1'b0}};
            key_event_r   <= 1'b0;
            last_key_r    <= KEY_NONE;
        end else begin
            press_state_r <= press_state_s;
            cand_r        <= cand_s;
            cnt_r         <= cnt_s;
            key_event_r   <= key_event_s;
            last_key_r    <= last_key_s;
        end
    end

    // Press FSM next state: a press or a release needs DEBOUNCE_CYCLES identical samples
    always_comb begin
        press_state_s = press_state_r;
        cand_s        = cand_r;
        cnt_s         = cnt_r;
        case (press_state_r)
            RELEASED: begin
                if (key_valid_s) begin
                    cand_s        = key_code;
                    cnt_s         = CW'(1);
                    press_state_s = (DEBOUNCE_CYCLES == 1) ? PRESSED : ARMING;
                end else begin
                    cnt_s         = {CW{1'b0}};
                end
            end
            ARMING: begin
                if (!key_valid_s) begin
                    cnt_s         = {CW{1'b0}};
                    press_state_s = RELEASED;
                end else if (key_code == cand_r) begin
                    if (cnt_r == CNT_LAST) begin
                        press_state_s = PRESSED;
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end else begin
                    cand_s = key_code;
                    cnt_s  = CW'(1);
                end
            end
            PRESSED: begin
                if (!key_valid_s) begin
                    cnt_s         = (DEBOUNCE_CYCLES == 1) ? {CW{1'b0}} : CW'(1);
                    press_state_s = (DEBOUNCE_CYCLES == 1) ? RELEASED : RELEASING;
                end else begin
                    cnt_s = {CW{1'b0}};
                end
            end
            RELEASING: begin
                if (key_valid_s) begin
                    cnt_s         = {CW{1'b0}};
                    press_state_s = PRESSED;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_s         = {CW{1'b0}};
                    press_state_s = RELEASED;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                cnt_s         = {CW{1'b0}};
                press_state_s = RELEASED;
            end
        endcase
    end

    // Press FSM outputs: the event fires on the sample that completes the press debounce
    always_comb begin
        key_event_s = 1'b0;
        case (press_state_r)
            RELEASED: begin
                if (key_valid_s && (DEBOUNCE_CYCLES == 1)) key_event_s = 1'b1;
                else                                       key_event_s = 1'b0;
            end
            ARMING: begin
                if (key_valid_s && (key_code == cand_r) && (cnt_r == CNT_LAST)) key_event_s = 1'b1;
                else                                                           key_event_s = 1'b0;
            end
            default: key_event_s = 1'b0;
        endcase
        if (key_event_s) last_key_s = key_code;
        else             last_key_s = last_key_r;
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_r;
    logic          timeout_r;

    assign tmo_fire_s = (entry_state_r == COLLECT) && !key_event_r &&
                        (digit_count_r != {DW{1'b0}}) && (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));

    // Inactivity counter, only running while a partial entry sits in COLLECT
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt_r <= {TW{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= tmo_fire_s;
            if ((entry_state_r != COLLECT) || key_event_r ||
                (digit_count_r == {DW{1'b0}}) || tmo_fire_s) begin
                tmo_cnt_r <= {TW{1'b0}};
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end
        end
    end

    assign timeout = timeout_r;
`else
    assign tmo_fire_s = 1'b0;
`endif

    // Entry FSM state and registered entry outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            entry_state_r <= COLLECT;
            entry_bcd_r   <= {EW{1'b0}};
            digit_count_r <= {DW{1'b0}};
            overflow_r    <= 1'b0;
            entry_valid_r <= 1'b0;
        end else begin
            entry_state_r <= entry_state_s;
            entry_bcd_r   <= entry_bcd_s;
            digit_count_r <= digit_count_s;
            overflow_r    <= overflow_s;
            entry_valid_r <= entry_valid_s;
        end
    end

    // Entry FSM next state: key events edit the entry only while collecting
    always_comb begin
        entry_state_s = entry_state_r;
        entry_bcd_s   = entry_bcd_r;
        digit_count_s = digit_count_r;
        overflow_s    = 1'b0;
        case (entry_state_r)
            COLLECT: begin
                if (key_event_r) begin
                    if (is_digit(last_key_r)) begin
                        if (digit_count_r < DW'(MAX_DIGITS)) begin
                            entry_bcd_s   = (entry_bcd_r << 4'd4) | EW'(last_key_r);
                            digit_count_s = digit_count_r + DW'(1);
                        end else begin
                            overflow_s = 1'b1;
                        end
                    end else if (last_key_r == KEY_BKSP) begin
                        if (digit_count_r != {DW{1'b0}}) begin
                            entry_bcd_s   = entry_bcd_r >> 4'd4;
                            digit_count_s = digit_count_r - DW'(1);
                        end else begin
                            digit_count_s = digit_count_r;
                        end
                    end else if (last_key_r == KEY_ENTER) begin
                        if (digit_count_r != {DW{1'b0}}) entry_state_s = PRESENT;
                        else                             entry_state_s = COLLECT;
                    end else begin
                        entry_state_s = COLLECT;
                    end
                end else if (tmo_fire_s) begin
                    entry_bcd_s   = {EW{1'b0}};
                    digit_count_s = {DW{1'b0}};
                end else begin
                    entry_state_s = COLLECT;
                end
            end
            PRESENT: begin
                // entry_valid is always high here, so entry_ready alone completes the handshake
                if (entry_ready) begin
                    entry_state_s = COLLECT;
                    entry_bcd_s   = {EW{1'b0}};
                    digit_count_s = {DW{1'b0}};
                end else begin
                    entry_state_s = PRESENT;
                end
            end
            default: begin
                entry_state_s = COLLECT;
                entry_bcd_s   = {EW{1'b0}};
                digit_count_s = {DW{1'b0}};
            end
        endcase
    end

    // Entry FSM outputs
    always_comb begin
        entry_valid_s = 1'b0;
        if (entry_state_s == PRESENT) entry_valid_s = 1'b1;
        else                          entry_valid_s = 1'b0;
    end

    assign key_event   = key_event_r;
    assign last_key    = last_key_r;
    assign entry_bcd   = entry_bcd_r;
    assign digit_count = digit_count_r;
    assign overflow    = overflow_r;
    assign entry_valid = entry_valid_r;

endmodule
